// File: rtl/seg_frame_demux.sv
// Serial-to-parallel demux for the 7-segment path: four accepted beats fill the
// shadow digits, then a single COMMIT cycle updates all four digit outputs at once.
module seg_frame_demux #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sync,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_data_3,
  output logic              o_frame_done,
  output logic              o_err
);

  typedef enum logic {FILL, COMMIT} state_t;

  localparam logic [15:0] IdleLast = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [15:0]       idle_q, idle_d;
  logic [DATA_W-1:0] shadow_q [4];
  logic [DATA_W-1:0] shadow_d [4];
  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              active_q;
  logic              accept;
  logic [1:0]        ptr_eff;

  // active_q keeps o_ready low until the first edge after reset release
  assign o_ready      = active_q && (state_q == FILL);
  assign accept       = i_valid && o_ready;
  assign ptr_eff      = i_sync ? 2'd0 : ptr_q;
  assign o_data_0     = data_q[0];
  assign o_data_1     = data_q[1];
  assign o_data_2     = data_q[2];
  assign o_data_3     = data_q[3];
  assign o_frame_done = done_q;
  assign o_err        = err_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idle_d   = idle_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      FILL: begin
        if (i_sync) begin
          ptr_d  = 2'd0;
          idle_d = 16'd0;
        end
        if (accept) begin
          shadow_d[ptr_eff] = i_data;
          ptr_d             = 2'(ptr_eff + 2'd1);
          idle_d            = 16'd0;
          if (ptr_eff == 2'd3) state_d = COMMIT;
        end else if (!i_sync) begin
          // An accept on the expiry cycle takes priority over the timeout
          if (ptr_q != 2'd0 && TIMEOUT != 0) begin
            if (idle_q == IdleLast) begin
              ptr_d  = 2'd0;
              idle_d = 16'd0;
              err_d  = 1'b1;
            end else begin
              idle_d = idle_q + 16'd1;
            end
          end else begin
            idle_d = 16'd0;
          end
        end
      end
      COMMIT: begin
        data_d  = shadow_q;
        ptr_d   = 2'd0;
        idle_d  = 16'd0;
        done_d  = 1'b1;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= FILL;
      ptr_q    <= 2'd0;
      idle_q   <= 16'd0;
      shadow_q <= '{default: '0};
      data_q   <= '{default: '0};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idle_q   <= idle_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_frame_demux.sv
// Scoreboard bench for seg_frame_demux: a queue-based frame model predicts commits
// and timeout errors; a monitor compares DUT outputs every cycle on the falling edge.
module tb_seg_frame_demux;

  localparam int TMO = 8;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_sync;
  logic       o_ready;
  logic [7:0] o_data_0, o_data_1, o_data_2, o_data_3;
  logic       o_frame_done;
  logic       o_err;

  seg_frame_demux #(.DATA_W(8), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_sync(i_sync),
    .o_data_0(o_data_0), .o_data_1(o_data_1), .o_data_2(o_data_2), .o_data_3(o_data_3),
    .o_frame_done(o_frame_done), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } frame_t;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [7:0]  curQ[$];
  frame_t      frameQ[$];
  int          errQ[$];
  int          cyc = 0;
  int          idleM = 0;
  bit          commitM = 0;
  bit          readyOk = 0;
  bit          lastAcc = 0;
  int          errTotal = 0;
  int          lastErrCyc = 0;
  int          accCyc = 0;
  logic [31:0] shown = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Frame-level model: beats collect in a queue, four beats form a frame
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      curQ.delete();
      frameQ.delete();
      errQ.delete();
      commitM = 0;
      readyOk = 0;
      idleM   = 0;
      lastAcc = 0;
    end else begin
      bit acc;
      cyc++;
      acc = i_valid && readyOk && !commitM;
      lastAcc = acc;
      if (commitM) begin
        commitM = 0;
      end else if (readyOk) begin
        if (i_sync) begin
          curQ.delete();
          idleM = 0;
        end
        if (acc) begin
          curQ.push_back(i_data);
          idleM = 0;
          if (curQ.size() == 4) begin
            frameQ.push_back('{cyc + 1, {curQ[3], curQ[2], curQ[1], curQ[0]}});
            curQ.delete();
            commitM = 1;
          end
        end else if (!i_sync && curQ.size() != 0) begin
          if (idleM == TMO - 1) begin
            curQ.delete();
            idleM = 0;
            errQ.push_back(cyc);
            errTotal++;
            lastErrCyc = cyc;
          end else begin
            idleM++;
          end
        end
      end
      readyOk = 1;
    end
  end

  always @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shown = '0;
    end else begin
      checkOutput("ready", {31'd0, o_ready}, {31'd0, readyOk && !commitM});
      if (frameQ.size() != 0 && frameQ[0].cyc == cyc) begin
        frame_t f;
        f = frameQ.pop_front();
        checkOutput("frameDone", {31'd0, o_frame_done}, 32'd1);
        shown = f.data;
      end else begin
        checkOutput("noFrameDone", {31'd0, o_frame_done}, 32'd0);
      end
      if (errQ.size() != 0 && errQ[0] == cyc) begin
        void'(errQ.pop_front());
        checkOutput("errPulse", {31'd0, o_err}, 32'd1);
      end else begin
        checkOutput("noErr", {31'd0, o_err}, 32'd0);
      end
      checkOutput("digits", {o_data_3, o_data_2, o_data_1, o_data_0}, shown);
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input bit s);
    int n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_sync  = s;
    do begin
      @(posedge i_clk);
      #1;
      n++;
    end while (!lastAcc && n < 20);
    if (!lastAcc) checkOutput("acceptStall", 32'd0, 32'd1);
    accCyc  = cyc;
    i_valid = 1'b0;
    i_sync  = 1'b0;
    i_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int prevAcc;
    int errBefore;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_sync  = 1'b0;
    i_data  = 8'h00;
    #23;
    i_rst_n = 1'b1;
    #1;
    checkOutput("readyInReleaseCycle", {31'd0, o_ready}, 32'd0);
    checkOutput("resetDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'd0);
    @(posedge i_clk);
    #1;

    // Basic frame with back-to-back beats, then a 5th beat right after COMMIT
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h04, 0);
    prevAcc = accCyc;
    applyStimulus(8'h55, 0);
    checkOutput("fifthBeatLatency", 32'(accCyc - prevAcc), 32'd2);
    idle(12);

    // Gapped valid
    applyStimulus(8'h01, 0); idle(3);
    applyStimulus(8'h02, 0); idle(3);
    applyStimulus(8'h03, 0); idle(3);
    applyStimulus(8'h04, 0); idle(3);

    // Resync discards AA/BB
    errBefore = errTotal;
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    applyStimulus(8'h11, 1);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    idle(2);
    checkOutput("resyncDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'h44332211);
    checkOutput("resyncNoErr", 32'(errTotal), 32'(errBefore));

    // Timeout drops a partial frame exactly TMO cycles after the last accept
    applyStimulus(8'hC1, 0);
    applyStimulus(8'hC2, 0);
    idle(10);
    checkOutput("errDelay", 32'(lastErrCyc - accCyc), 32'(TMO));
    checkOutput("timeoutKeepsDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'h44332211);
    applyStimulus(8'hD0, 0);
    applyStimulus(8'hD1, 0);
    applyStimulus(8'hD2, 0);
    applyStimulus(8'hD3, 0);
    idle(2);
    checkOutput("postTimeoutDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'hD3D2D1D0);

    // Beat presented on the expiry cycle wins over the timeout
    errBefore = errTotal;
    applyStimulus(8'hE0, 0);
    idle(TMO - 1);
    applyStimulus(8'hE1, 0);
    applyStimulus(8'hE2, 0);
    applyStimulus(8'hE3, 0);
    idle(2);
    checkOutput("expiryAcceptNoErr", 32'(errTotal), 32'(errBefore));
    checkOutput("expiryDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'hE3E2E1E0);

    // Asynchronous reset mid-frame
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h04, 0);
    idle(2);
    applyStimulus(8'h77, 0);
    applyStimulus(8'h78, 0);
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("asyncResetDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'd0);
    checkOutput("asyncResetReady", {31'd0, o_ready}, 32'd0);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    applyStimulus(8'h05, 0);
    applyStimulus(8'h06, 0);
    applyStimulus(8'h07, 0);
    applyStimulus(8'h08, 0);
    idle(2);
    checkOutput("afterResetDigits", {o_data_3, o_data_2, o_data_1, o_data_0}, 32'h08070605);

    // Randomized traffic with occasional resync and idle gaps around the timeout
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 6) applyStimulus(8'($urandom), $urandom_range(0, 7) == 0);
      else idle($urandom_range(1, 11));
    end
    idle(TMO + 6);

    checkOutput("frameQueueDrained", 32'(frameQ.size()), 32'd0);
    checkOutput("errQueueDrained", 32'(errQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_frame_demux.md
Name: seg_frame_demux

Overview:
Inverse of the digit MUX in the 7-segment path. Accepts a serial stream of 8-bit segment patterns over a valid/ready handshake and distributes them round-robin into four digit registers. The registers are double-buffered, so the display-side MUX sees all four digits change in the same cycle. Sits between the pattern source (encoder/CPU) and the digit MUX inputs.

Parameters:
DATA_W, 8, width of one digit pattern
TIMEOUT, 1000, idle cycles allowed mid-frame before the partial frame is discarded; 0 disables; legal range 0..65535

Ports:
i_clk  in  1  clock, all state updates on the rising edge
i_rst_n  in  1  asynchronous active-low reset
i_data  in  DATA_W  incoming digit pattern
i_valid  in  1  i_data is valid this cycle
o_ready  out  1  block can accept a beat this cycle
i_sync  in  1  synchronous frame restart; next accepted beat is digit 0
o_data_0  out  DATA_W  committed pattern, digit 0
o_data_1  out  DATA_W  committed pattern, digit 1
o_data_2  out  DATA_W  committed pattern, digit 2
o_data_3  out  DATA_W  committed pattern, digit 3
o_frame_done  out  1  one-cycle pulse; outputs were just committed
o_err  out  1  one-cycle pulse; partial frame dropped by timeout

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - o_data_0..3 = 0; shadow regs = 0; ptr = 0; idle counter = 0.
  - State = FILL; o_frame_done = 0; o_err = 0.
  - o_ready = 0 while reset is asserted, 1 from the first cycle after release.
- Accept: a beat transfers on a rising edge with i_valid=1 and o_ready=1. Shadow[ptr] <= i_data, ptr <= ptr+1 (2-bit).
- States:
  - FILL: o_ready=1.
    - Accept with ptr=3 -> COMMIT.
    - Otherwise stay in FILL.
  - COMMIT (exactly one cycle): o_ready=0.
    - On its edge: o_data_k <= shadow[k] for all k, simultaneously.
    - ptr <= 0, state <= FILL.
    - o_frame_done is registered: high for the single cycle following the COMMIT edge.
- Latency: 4th beat accepted at edge N -> o_data_0..3 new and o_frame_done=1 from edge N+1 to edge N+2. o_data holds its value until the next commit.
- Partial frames never reach the outputs; o_data only changes at commit.
- i_sync (sampled in FILL only):
  - ptr <= 0 and the idle counter clears.
  - Shadow contents are not cleared; they are overwritten by later beats.
  - i_sync with an accepted beat in the same cycle: the beat is written as digit 0 and ptr <= 1.
  - i_sync during COMMIT is ignored; the commit completes.
- Timeout (TIMEOUT>0):
  - The idle counter increments each FILL cycle with ptr!=0 and no accept. It clears on accept, i_sync, or ptr=0.
  - When the counter reaches TIMEOUT-1 with no accept that cycle: ptr <= 0, counter <= 0, o_err high for the next cycle. Outputs are unchanged.
  - An accept in the same cycle as expiry wins: the beat is taken, and there is no error.
  - TIMEOUT=0: the counter is held at 0 and o_err is never asserted.
- Counter width: 16 bits, no wrap possible within the legal TIMEOUT range.
- o_frame_done and o_err are never both high in the same cycle.
- Reset mid-frame or mid-COMMIT: everything returns to reset values immediately, including o_data_0..3 = 0.
- i_data is ignored when i_valid=0 or o_ready=0. The source must hold i_data and i_valid until accepted.

Test Plan:
- Basic frame: after reset, send 0x01,0x02,0x03,0x04 with i_valid held high -> o_ready drops for one cycle after the 4th beat; o_data_0..3 = 01,02,03,04 together; one-cycle o_frame_done; a 5th beat is accepted on the cycle after COMMIT.
- Gapped valid: send the same four beats with 3-cycle gaps (TIMEOUT=1000) -> identical result; o_data unchanged (still 0) until the 4th beat commits.
- Resync: send 0xAA,0xBB, then assert i_sync together with 0x11, then 0x22,0x33,0x44 -> commit shows 11,22,33,44; 0xAA and 0xBB are discarded; no o_err.
- Timeout: TIMEOUT=8; send two beats then idle -> o_err pulses exactly 8 cycles after the last accept; outputs keep the previous frame; the next 4 beats commit as digits 0..3.
- Reset mid-frame: a committed frame 01..04 is showing; send 2 beats of the next frame; pulse i_rst_n low asynchronously between edges -> outputs are 0 immediately; after release, a full frame 05..08 commits correctly.
- Accept on expiry edge: TIMEOUT=4; after one beat, idle 3 cycles, then present a beat on the expiry cycle -> the beat is accepted as digit 1; no o_err.
